// File: rtl/command_parser.sv
// command_parser: turns a (cmd, address, value) word stream into register-file
// write strobes and read requests, and serialises read responses back out as a
// handshaked word stream. Bad commands, frame timeouts and overruns are reported
// through a one-cycle error pulse plus a sticky error code.
module command_parser #(
    parameter int                    WORD_WIDTH     = 8,
    parameter int                    ADDR_WORDS     = 1,
    parameter int                    VALUE_WORDS    = 4,
    parameter logic [WORD_WIDTH-1:0] CMD_WRITE      = 8'h57,
    parameter logic [WORD_WIDTH-1:0] CMD_READ       = 8'h52,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              i_reset_n,
    input  logic [WORD_WIDTH-1:0]             i_data,
    input  logic                              i_dv,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0]  o_w_addr,
    output logic [VALUE_WORDS*WORD_WIDTH-1:0] o_w_data,
    output logic                              o_w_en,
    output logic [ADDR_WORDS*WORD_WIDTH-1:0]  o_r_addr,
    output logic                              o_r_en,
    input  logic [VALUE_WORDS*WORD_WIDTH-1:0] i_r_data,
    input  logic                              i_r_dv,
    output logic [WORD_WIDTH-1:0]             o_tx_data,
    output logic                              o_tx_valid,
    input  logic                              i_tx_ready,
    output logic                              o_busy,
    output logic                              o_err,
    output logic [1:0]                        o_err_code
);

    localparam int AW        = ADDR_WORDS * WORD_WIDTH;
    localparam int VW        = VALUE_WORDS * WORD_WIDTH;
    localparam int MAX_WORDS = (ADDR_WORDS > VALUE_WORDS) ? ADDR_WORDS : VALUE_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int TO_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_WORDS - 1);
    localparam logic [CNT_W-1:0] VALUE_LAST = CNT_W'(VALUE_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ERR_BAD_CMD = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RD_WAIT,
        TX
    } state_t;

    state_t            state, state_nx;
    logic              is_read, is_read_nx;
    logic [AW-1:0]     addr_sr, addr_nx, addr_shift;
    logic [VW-1:0]     data_sr, data_nx, data_shift;
    logic [VW-1:0]     tx_sr, tx_nx;
    logic [CNT_W-1:0]  word_cnt, cnt_nx;
    logic [TO_W-1:0]   to_cnt, to_nx;
    logic              timeout_hit;

    logic [AW-1:0]     w_addr_nx, r_addr_nx;
    logic [VW-1:0]     w_data_nx;
    logic              w_en_nx, r_en_nx, err_nx;
    logic [1:0]        err_code_nx;

    // Frames arrive most-significant word first, so each new word enters at the bottom.
    assign addr_shift = (addr_sr << WORD_WIDTH) | AW'(i_data);
    assign data_shift = (data_sr << WORD_WIDTH) | VW'(i_data);

    assign o_tx_valid = (state == TX);
    assign o_tx_data  = tx_sr[VW-1 -: WORD_WIDTH];
    assign o_busy     = (state == RD_WAIT) || (state == TX);

    // State register and all registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            is_read    <= 1'b0;
            addr_sr    <= '0;
            data_sr    <= '0;
            tx_sr      <= '0;
            word_cnt   <= '0;
            to_cnt     <= '0;
            o_w_addr   <= '0;
            o_w_data   <= '0;
            o_w_en     <= 1'b0;
            o_r_addr   <= '0;
            o_r_en     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= 2'b00;
        end else begin
            state      <= state_nx;
            is_read    <= is_read_nx;
            addr_sr    <= addr_nx;
            data_sr    <= data_nx;
            tx_sr      <= tx_nx;
            word_cnt   <= cnt_nx;
            to_cnt     <= to_nx;
            o_w_addr   <= w_addr_nx;
            o_w_data   <= w_data_nx;
            o_w_en     <= w_en_nx;
            o_r_addr   <= r_addr_nx;
            o_r_en     <= r_en_nx;
            o_err      <= err_nx;
            o_err_code <= err_code_nx;
        end
    end

    // Next-state, frame assembly, response serialisation, timeout and error decode.
    always_comb begin
        state_nx    = state;
        is_read_nx  = is_read;
        addr_nx     = addr_sr;
        data_nx     = data_sr;
        tx_nx       = tx_sr;
        cnt_nx      = word_cnt;
        to_nx       = '0;
        timeout_hit = 1'b0;
        w_addr_nx   = o_w_addr;
        w_data_nx   = o_w_data;
        w_en_nx     = 1'b0;
        r_addr_nx   = o_r_addr;
        r_en_nx     = 1'b0;
        err_nx      = 1'b0;
        err_code_nx = o_err_code;

        if ((TIMEOUT_CYCLES > 0) && ((state == ADDR) || (state == DATA) || (state == RD_WAIT))) begin
            if (i_dv || ((state == RD_WAIT) && i_r_dv)) begin
                to_nx = '0;
            end else if (to_cnt >= TO_LAST) begin
                timeout_hit = 1'b1;
                to_nx       = to_cnt;
            end else begin
                to_nx = to_cnt + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (i_dv) begin
                    if ((i_data == CMD_WRITE) || (i_data == CMD_READ)) begin
                        is_read_nx = (i_data == CMD_READ);
                        state_nx   = ADDR;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = ERR_BAD_CMD;
                    end
                end
            end

            ADDR: begin
                if (i_dv) begin
                    addr_nx = addr_shift;
                    if (word_cnt == ADDR_LAST) begin
                        cnt_nx = '0;
                        if (is_read) begin
                            r_addr_nx = addr_shift;
                            r_en_nx   = 1'b1;
                            state_nx  = RD_WAIT;
                        end else begin
                            state_nx = DATA;
                        end
                    end else begin
                        cnt_nx = word_cnt + 1'b1;
                    end
                end else if (timeout_hit) begin
                    err_nx      = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    addr_nx     = '0;
                    data_nx     = '0;
                end
            end

            DATA: begin
                if (i_dv) begin
                    data_nx = data_shift;
                    if (word_cnt == VALUE_LAST) begin
                        w_addr_nx = addr_sr;
                        w_data_nx = data_shift;
                        w_en_nx   = 1'b1;
                        cnt_nx    = '0;
                        state_nx  = IDLE;
                    end else begin
                        cnt_nx = word_cnt + 1'b1;
                    end
                end else if (timeout_hit) begin
                    err_nx      = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    addr_nx     = '0;
                    data_nx     = '0;
                end
            end

            RD_WAIT: begin
                if (i_r_dv) begin
                    tx_nx    = i_r_data;
                    cnt_nx   = '0;
                    state_nx = TX;
                end else if (timeout_hit) begin
                    err_nx      = 1'b1;
                    err_code_nx = ERR_TIMEOUT;
                    state_nx    = IDLE;
                    cnt_nx      = '0;
                    addr_nx     = '0;
                end
                if (i_dv) begin
                    err_nx      = 1'b1;
                    err_code_nx = ERR_OVERRUN;
                end
            end

            TX: begin
                if (i_tx_ready) begin
                    tx_nx = tx_sr << WORD_WIDTH;
                    if (word_cnt == VALUE_LAST) begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = word_cnt + 1'b1;
                    end
                end
                if (i_dv) begin
                    err_nx      = 1'b1;
                    err_code_nx = ERR_OVERRUN;
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_command_parser.sv
// Testbench for command_parser: directed frames from the test plan followed by
// randomized write/read/bad-command frames checked against a frame-level model
// of the register file behind the parser.
module tb_command_parser;

    logic        clk;
    logic        i_reset_n;
    logic [7:0]  i_data;
    logic        i_dv;
    logic [7:0]  o_w_addr;
    logic [31:0] o_w_data;
    logic        o_w_en;
    logic [7:0]  o_r_addr;
    logic        o_r_en;
    logic [31:0] i_r_data;
    logic        i_r_dv;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_err;
    logic [1:0]  o_err_code;

    logic [7:0]  d2_data;
    logic        d2_dv;
    logic [15:0] d2_w_addr;
    logic [31:0] d2_w_data;
    logic        d2_w_en;
    logic [15:0] d2_r_addr;
    logic        d2_r_en;
    logic [31:0] d2_r_data;
    logic        d2_r_dv;
    logic [7:0]  d2_tx_data;
    logic        d2_tx_valid;
    logic        d2_tx_ready;
    logic        d2_busy;
    logic        d2_err;
    logic [1:0]  d2_err_code;

    int assert_count = 0;
    int fail_count   = 0;
    int w_en_seen    = 0;
    int r_en_seen    = 0;
    int err_seen     = 0;
    int exp_w        = 0;
    int exp_r        = 0;
    int exp_err      = 0;

    logic [31:0] mem [256];

    command_parser #(
        .WORD_WIDTH(8), .ADDR_WORDS(1), .VALUE_WORDS(4),
        .CMD_WRITE(8'h57), .CMD_READ(8'h52), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .i_reset_n(i_reset_n), .i_data(i_data), .i_dv(i_dv),
        .o_w_addr(o_w_addr), .o_w_data(o_w_data), .o_w_en(o_w_en),
        .o_r_addr(o_r_addr), .o_r_en(o_r_en), .i_r_data(i_r_data), .i_r_dv(i_r_dv),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
    );

    command_parser #(
        .WORD_WIDTH(8), .ADDR_WORDS(2), .VALUE_WORDS(4),
        .CMD_WRITE(8'h57), .CMD_READ(8'h52), .TIMEOUT_CYCLES(1024)
    ) dut2 (
        .clk(clk), .i_reset_n(i_reset_n), .i_data(d2_data), .i_dv(d2_dv),
        .o_w_addr(d2_w_addr), .o_w_data(d2_w_data), .o_w_en(d2_w_en),
        .o_r_addr(d2_r_addr), .o_r_en(d2_r_en), .i_r_data(d2_r_data), .i_r_dv(d2_r_dv),
        .o_tx_data(d2_tx_data), .o_tx_valid(d2_tx_valid), .i_tx_ready(d2_tx_ready),
        .o_busy(d2_busy), .o_err(d2_err), .o_err_code(d2_err_code)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every strobe cycle so duplicated or spurious pulses show up in totals.
    always @(negedge clk) begin
        if (o_w_en) w_en_seen <= w_en_seen + 1;
        if (o_r_en) r_en_seen <= r_en_seen + 1;
        if (o_err)  err_seen  <= err_seen + 1;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] w, input int gap);
        repeat (gap) tick();
        i_dv   = 1'b1;
        i_data = w;
        tick();
        i_dv   = 1'b0;
        i_data = 8'h00;
    endtask

    task automatic d2Send(input logic [7:0] w);
        d2_dv   = 1'b1;
        d2_data = w;
        tick();
        d2_dv   = 1'b0;
    endtask

    task automatic runWrite(input logic [7:0] addr, input logic [31:0] value, input int max_gap);
        applyStimulus(8'h57, $urandom_range(0, max_gap));
        applyStimulus(addr, $urandom_range(0, max_gap));
        for (int i = 3; i >= 0; i--) applyStimulus(value[8*i +: 8], $urandom_range(0, max_gap));
        checkOutput("w_en", o_w_en, 1);
        checkOutput("w_addr", o_w_addr, addr);
        checkOutput("w_data", o_w_data, value);
        checkOutput("w_r_en_quiet", o_r_en, 0);
        mem[addr] = value;
        exp_w++;
        tick();
        checkOutput("w_en_pulse", o_w_en, 0);
    endtask

    task automatic runRead(input logic [7:0] addr, input int lat, input logic [7:0] pat,
                           input bit use_pat, input int ovr_step, input int max_gap);
        logic [31:0] resp;
        int idx;
        int step;
        resp = mem[addr];
        applyStimulus(8'h52, $urandom_range(0, max_gap));
        applyStimulus(addr, $urandom_range(0, max_gap));
        checkOutput("r_en", o_r_en, 1);
        checkOutput("r_addr", o_r_addr, addr);
        checkOutput("busy_rd_wait", o_busy, 1);
        exp_r++;
        tick();
        checkOutput("r_en_pulse", o_r_en, 0);
        repeat (lat - 1) tick();
        i_r_dv   = 1'b1;
        i_r_data = resp;
        tick();
        i_r_dv   = 1'b0;
        i_r_data = $urandom;
        idx  = 0;
        step = 0;
        while (idx < 4 && step < 200) begin
            if (use_pat && step < 8) i_tx_ready = pat[step];
            else i_tx_ready = ($urandom_range(0, 2) != 0);
            checkOutput("tx_valid", o_tx_valid, 1);
            checkOutput("tx_data", o_tx_data, resp[8*(3-idx) +: 8]);
            if (step == ovr_step) begin
                i_dv   = 1'b1;
                i_data = 8'h57;
            end
            tick();
            i_dv = 1'b0;
            if (step == ovr_step) begin
                checkOutput("ovr_err", o_err, 1);
                checkOutput("ovr_code", o_err_code, 2'b11);
                exp_err++;
            end
            if (i_tx_ready) idx++;
            step++;
        end
        i_tx_ready = 1'b0;
        checkOutput("tx_words", idx, 4);
        checkOutput("busy_after_tx", o_busy, 0);
        checkOutput("tx_valid_after", o_tx_valid, 0);
    endtask

    task automatic runBadCmd(input logic [7:0] w, input int gap);
        applyStimulus(w, gap);
        checkOutput("bad_err", o_err, 1);
        checkOutput("bad_code", o_err_code, 2'b01);
        checkOutput("bad_no_w", o_w_en, 0);
        checkOutput("bad_no_r", o_r_en, 0);
        exp_err++;
        tick();
        checkOutput("bad_err_pulse", o_err, 0);
    endtask

    // Directed test plan followed by randomized frames.
    initial begin
        logic [31:0] v;
        i_reset_n   = 1'b0;
        i_data      = 8'h00;
        i_dv        = 1'b0;
        i_r_data    = 32'h0;
        i_r_dv      = 1'b0;
        i_tx_ready  = 1'b0;
        d2_data     = 8'h00;
        d2_dv       = 1'b0;
        d2_r_data   = 32'h0;
        d2_r_dv     = 1'b0;
        d2_tx_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h22] = 32'hCAFEF00D;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_w_en", o_w_en, 0);
        checkOutput("rst_w_addr", o_w_addr, 0);
        checkOutput("rst_w_data", o_w_data, 0);
        checkOutput("rst_r_en", o_r_en, 0);
        checkOutput("rst_r_addr", o_r_addr, 0);
        checkOutput("rst_tx_valid", o_tx_valid, 0);
        checkOutput("rst_tx_data", o_tx_data, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_err_code", o_err_code, 0);
        i_reset_n = 1'b1;
        tick();

        $display("[TB] directed write 57,10,DE,AD,BE,EF");
        runWrite(8'h10, 32'hDEADBEEF, 0);

        $display("[TB] directed read 52,22 with ready 1,0,1,1,1");
        runRead(8'h22, 3, 8'b1111_1101, 1'b1, -1, 0);

        $display("[TB] bad command 41 then a valid write");
        runBadCmd(8'h41, 0);
        runWrite(8'h33, 32'h01234567, 0);

        $display("[TB] timeout after 57,10,DE");
        applyStimulus(8'h57, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'hDE, 0);
        repeat (15) tick();
        checkOutput("to_not_yet", o_err, 0);
        tick();
        checkOutput("to_err", o_err, 1);
        checkOutput("to_code", o_err_code, 2'b10);
        exp_err++;
        tick();
        checkOutput("to_err_pulse", o_err, 0);
        checkOutput("to_code_held", o_err_code, 2'b10);
        checkOutput("to_no_write", o_w_en, 0);
        v = $urandom;
        runWrite(8'h11, v, 0);

        $display("[TB] overrun during response");
        runRead(8'h10, 2, 8'b1111_1101, 1'b1, 1, 0);
        tick();
        checkOutput("ovr_no_write", o_w_en, 0);

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            int kind;
            int ovr;
            logic [7:0] a;
            logic [7:0] bad;
            kind = int'($urandom_range(0, 9));
            a    = 8'($urandom);
            v    = $urandom;
            if (kind == 0) begin
                bad = 8'($urandom);
                while (bad == 8'h57 || bad == 8'h52) bad = 8'($urandom);
                runBadCmd(bad, int'($urandom_range(0, 3)));
            end else if (kind <= 5) begin
                runWrite(a, v, 4);
            end else begin
                ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
                runRead(a, int'($urandom_range(1, 5)), 8'h00, 1'b0, ovr, 4);
            end
        end

        $display("[TB] two-word address variant");
        d2Send(8'h57);
        d2Send(8'h12);
        d2Send(8'h34);
        d2Send(8'hDE);
        d2Send(8'hAD);
        d2Send(8'hBE);
        d2Send(8'hEF);
        checkOutput("d2_w_en", d2_w_en, 1);
        checkOutput("d2_w_addr", d2_w_addr, 16'h1234);
        checkOutput("d2_w_data", d2_w_data, 32'hDEADBEEF);
        tick();
        d2Send(8'h52);
        d2Send(8'hAB);
        d2Send(8'hCD);
        checkOutput("d2_r_en", d2_r_en, 1);
        checkOutput("d2_r_addr", d2_r_addr, 16'hABCD);
        checkOutput("d2_busy", d2_busy, 1);

        $display("[TB] reset in the middle of a write frame");
        applyStimulus(8'h57, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'hDE, 0);
        #3;
        i_reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_w_addr", o_w_addr, 0);
        checkOutput("mid_rst_w_data", o_w_data, 0);
        checkOutput("mid_rst_err_code", o_err_code, 0);
        checkOutput("mid_rst_w_en", o_w_en, 0);
        checkOutput("mid_rst_d2_busy", d2_busy, 0);
        checkOutput("mid_rst_d2_w_addr", d2_w_addr, 0);
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        tick();
        checkOutput("post_rst_w_en", o_w_en, 0);
        runWrite(8'h44, 32'h55AA33CC, 1);

        repeat (2) tick();
        checkOutput("count_w_en", w_en_seen, exp_w);
        checkOutput("count_r_en", r_en_seen, exp_r);
        checkOutput("count_err", err_seen, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/command_parser.md
Name: command_parser

Overview:
- Parametrised successor to the write-only command controller.
- Parses a word stream (cmd, address, value) into register-file write strobes. Adds read commands with a handshaked serial response, multi-word addresses, a frame timeout and error reporting.
- Sits between the UART/byte receiver and the register file. The response stream feeds the transmitter.

Parameters:
- WORD_WIDTH, 8: width of one stream word.
- ADDR_WORDS, 1: address words per frame, MSB word first.
- VALUE_WORDS, 4: value words per write frame and per read response, MSB word first.
- CMD_WRITE, 8'h57: command word for write.
- CMD_READ, 8'h52: command word for read.
- TIMEOUT_CYCLES, 1024: idle cycles allowed inside a frame before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_data  in  WORD_WIDTH  stream word, valid when i_dv=1.
- i_dv  in  1  one-cycle strobe; each high cycle delivers one word.
- o_w_addr  out  ADDR_WORDS*WORD_WIDTH  write address.
- o_w_data  out  VALUE_WORDS*WORD_WIDTH  write data.
- o_w_en  out  1  write strobe, exactly 1 cycle.
- o_r_addr  out  ADDR_WORDS*WORD_WIDTH  read address.
- o_r_en  out  1  read request, exactly 1 cycle.
- i_r_data  in  VALUE_WORDS*WORD_WIDTH  read data.
- i_r_dv  in  1  i_r_data valid; 1-cycle strobe.
- o_tx_data  out  WORD_WIDTH  response word.
- o_tx_valid  out  1  response word valid.
- i_tx_ready  in  1  downstream accepts the word when valid&ready.
- o_busy  out  1  high in RD_WAIT and TX.
- o_err  out  1  1-cycle error pulse.
- o_err_code  out  2  01 bad command, 10 timeout, 11 overrun; held until the next error.

Behaviour:
- Reset: asynchronous on i_reset_n low, synchronous deassert path. All outputs and registers go to 0 and the state goes to IDLE. Reset mid-frame discards the frame; no o_w_en or o_r_en is emitted.
- A word is "accepted" on a rising clk edge where i_dv=1.
- States: IDLE, ADDR, DATA, RD_WAIT, TX.
- IDLE: on an accepted word:
  - word == CMD_WRITE or CMD_READ: latch the command and go to ADDR.
  - any other word: o_err=1 next cycle, code 01, stay in IDLE.
- ADDR: shift each accepted word into the address register (left shift, new word in the LSBs). After ADDR_WORDS accepted words:
  - write command: go to DATA.
  - read command: o_r_addr takes the address and o_r_en=1 in the next cycle; go to RD_WAIT.
- DATA: shift accepted words into the data register. On the VALUE_WORDS-th word:
  - o_w_addr and o_w_data update and o_w_en=1 in the next cycle (latency 1 from the last accepted word).
  - Go to IDLE in the same edge; a cmd word in the following cycle is accepted.
  - o_w_addr and o_w_data hold until the next write.
- RD_WAIT: on i_r_dv=1, latch i_r_data into the tx shift register and go to TX. i_r_dv in any other state is ignored.
- TX:
  - o_tx_valid=1 and o_tx_data = top word of the shift register.
  - On valid&ready: shift left one word and increment the count.
  - After VALUE_WORDS transfers, o_tx_valid=0 and go to IDLE.
  - o_tx_data is stable while valid&!ready.
- Overrun: an accepted i_dv in RD_WAIT or TX drops the word and pulses o_err with code 11. The state is unaffected.
- Timeout: a counter runs in ADDR, DATA and RD_WAIT.
  - It clears on any accepted word, or on i_r_dv in RD_WAIT.
  - When it reaches TIMEOUT_CYCLES consecutive idle cycles, o_err=1 next cycle with code 10, go to IDLE and discard the partial frame.
  - No timeout in TX; back-pressure is legal.
- Simultaneous error and write/read completion cannot occur. Priority within one edge: reset > completion > error.
- Counter widths: $clog2 of the maximum count + 1, no wrap. The timeout counter saturates.

Test Plan:
- Write frame 57,10,DE,AD,BE,EF with i_dv every cycle -> o_w_en 1 cycle after the EF edge, o_w_addr=10, o_w_data=DEADBEEF; o_r_en never asserted.
- Read frame 52,22; register file returns i_r_dv with CAFEF00D 3 cycles after o_r_en; i_tx_ready toggles 1,0,1,1,1 -> o_r_addr=22; o_tx_data sequence CA,FE,F0,0D with each word held during the ready=0 cycle; o_busy drops when the 4th word transfers.
- Word 41 in IDLE -> o_err pulse, o_err_code=01, no strobes; a following valid write frame completes normally.
- TIMEOUT_CYCLES=16: send 57,10,DE then silence -> o_err pulse 16 cycles after the DE edge with code 10; a new frame 57,11,... writes to address 11.
- Words sent during TX -> o_err with code 11, the response sequence is not corrupted, no spurious write.
- Assert i_reset_n low mid-DATA (after 57,10,DE) -> all outputs 0 asynchronously, no o_w_en; ADDR_WORDS=2 variant: 57,12,34,… -> o_w_addr=1234.
